// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide unit.
// Build option: MULDIV_DIV_EN enables the divide datapath (see muldiv_unit).
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 6;

   function automatic logic is_div(op_e op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the ALU and the multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: IDLE/RUN/DONE sequencing, 6-bit iteration counter, registered busy/done.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic accept_o,
   output logic step_o,
   output logic finish_o,
   output logic busy_o,
   output logic done_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_COUNT);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;

   // The counter runs 0..32: 32 iteration cycles, then one cycle that hands off to DONE.
   assign accept_o = start_i && (state_q != S_RUN);
   assign step_o   = (state_q == S_RUN) && (cnt_q != LAST_CNT);
   assign finish_o = (state_q == S_RUN) && (cnt_q == LAST_CNT);
   assign busy_o   = busy_q;
   assign done_o   = done_q;

   // State, counter and registered busy/done flags advance together.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (cnt_q == LAST_CNT) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-iteration shift-add multiplier and restoring divider sharing one hi:lo register pair.
// Build option: define MULDIV_DIV_EN to include the divide datapath; otherwise DIVU/REMU return 0
// with unchanged handshake and latency.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   op_e              op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
`endif

   logic accept, step, finish, busy, done;

   muldiv_ctrl u_ctrl (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (bus.start),
      .accept_o (accept),
      .step_o   (step),
      .finish_o (finish),
      .busy_o   (busy),
      .done_o   (done)
   );

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = res_q;

   // One iteration: lo holds a (multiplier bits / dividend bits), b_q is addend or divisor.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      sum  = '0;
`ifdef MULDIV_DIV_EN
      trial = {hi_q, lo_q[WIDTH-1]};
      diff  = trial - {1'b0, b_q};
      if (is_div(op_q)) begin
         if (trial >= {1'b0, b_q}) begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
`else
      begin
`endif
         sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Pick the half of hi:lo that the latched op asks for.
   always_comb begin
      res_d = '0;
      case (op_q)
         OP_MUL:   res_d = lo_q;
         OP_MULHU: res_d = hi_q;
`ifdef MULDIV_DIV_EN
         OP_DIVU:  res_d = lo_q;
         OP_REMU:  res_d = hi_q;
`endif
         default:  res_d = '0;
      endcase
   end

   // Latch on accept, iterate while counting, capture the result on the hand-off to DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q  <= OP_MUL;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         res_q <= '0;
      end else if (accept) begin
         op_q <= op_e'(bus.op);
         b_q  <= bus.b;
         hi_q <= '0;
         lo_q <= bus.a;
      end else if (step) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end else if (finish) begin
         res_q <= res_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected results come from plain arithmetic.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] res;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned busy_run = 0;
   exp_t        sb[$];

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Edge counter used to time done pulses.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (op)
         OP_MUL:   return p[31:0];
         OP_MULHU: return p[63:32];
`ifdef MULDIV_DIV_EN
         OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU:  return (b == 0) ? a : a % b;
`endif
         default:  return 32'h0;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge: present a request for one cycle and record its expected outcome.
   task automatic drive(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      e.res = model(op, a, b);
      e.cyc = cyc + 34;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      @(negedge clk);
      drive(op, a, b);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (bus.busy) busy_run++;
         if (bus.done) begin
            check("busy_in_done", {31'b0, bus.busy}, 32'h0);
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("result", bus.result, e.res);
               check("done_cycle", cyc, e.cyc);
               check("busy_cycles", busy_run, 32'd33);
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_done", {31'b0, bus.done}, 32'h0);
      check("rst_result", bus.result, 32'h0);
      rst_n = 1'b1;

      issue(OP_MUL, 32'd7, 32'd6);
      drain();
      @(negedge clk);
      check("mul_7x6_hold", bus.result, 32'd42);

      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      issue(OP_DIVU, 32'd100, 32'd7);
      drain();
      issue(OP_REMU, 32'd100, 32'd7);
      drain();
      issue(OP_DIVU, 32'h0000_1234, 32'h0);
      drain();
      issue(OP_REMU, 32'h0000_1234, 32'h0);
      drain();

      // start during RUN must not disturb the in-flight multiply
      issue(OP_MUL, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd9;
      bus.b     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      @(negedge clk);
      check("ignored_start_result", bus.result, 32'd15);

      // new request presented during the DONE cycle
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
      check("b2b_done_seen", {31'b0, bus.done}, 32'h1);
      drive(OP_MUL, 32'd1234, 32'd5678);
      drain();

      // reset in mid-operation, with start held high in the reset cycle
      issue(OP_MUL, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.a     = 32'd4;
      bus.b     = 32'd4;
      sb.delete();
      @(negedge clk);
      check("abort_busy", {31'b0, bus.busy}, 32'h0);
      check("abort_done", {31'b0, bus.done}, 32'h0);
      check("abort_result", bus.result, 32'h0);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_idle_busy", {31'b0, bus.busy}, 32'h0);
      check("abort_idle_result", bus.result, 32'h0);
      issue(OP_MUL, 32'd4, 32'd4);
      drain();
      @(negedge clk);
      check("post_reset_mul", bus.result, 32'd16);

      for (int n = 0; n < 40; n++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         issue(op, a, b);
         if ($urandom_range(0, 1) == 1) drain();
         else begin
            for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
            if (bus.done) drive(2'($urandom_range(0, 3)), pick(), pick());
            drain();
         end
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32. This is the operand and result width. Only 32 is supported.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request strobe, sampled on each rising edge of clk.
REQ-005 op  input  2  operation select: 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
REQ-006 a  input  32  operand A (multiplicand or dividend).
REQ-007 b  input  32  operand B (multiplier or divisor).
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  registered result, consumed by the ALU result mux.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 A request SHALL be accepted when start=1 at a rising edge in IDLE or DONE; on acceptance, op, a and b are latched, the iteration counter is cleared, and the state moves to RUN.
REQ-013 start while in RUN SHALL be ignored; the latched operands and op SHALL NOT change.
REQ-014 RUN SHALL perform exactly 32 iterations, one per cycle, then move to DONE.
  - MUL/MULHU: radix-2 shift-add, 64-bit product.
  - DIVU/REMU: restoring shift-subtract.
REQ-015 Latency: if start is accepted at edge N, done=1 during the cycle after edge N+33, and busy=1 from after edge N through edge N+32.
REQ-016 DONE SHALL last exactly one cycle and return to IDLE unless a new start is accepted in that cycle; done=1 and busy=0 in DONE.
REQ-017 result SHALL update only on entry to DONE and SHALL hold its value through IDLE and the following RUN until the next DONE.
REQ-018 Results by op:
  - MUL: product[31:0].
  - MULHU: product[63:32].
  - DIVU: floor(a/b).
  - REMU: a mod b.
  - All operands are unsigned; no overflow flag.
REQ-019 Divide by zero (b=0) SHALL still take the full 32 iterations.
  - DIVU returns 32'hFFFFFFFF.
  - REMU returns a.
REQ-020 Operands of 0 or 1 SHALL NOT shorten latency; there is no early termination.
REQ-021 The iteration counter SHALL be 6 bits and SHALL NOT wrap during a single operation.

Reset
REQ-022 rst_n=0 at a rising edge SHALL set state=IDLE, busy=0, done=0, result=32'h0, counter=0, latched operands=0.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation.
  - No done pulse is produced for the aborted request.
  - The first start after rst_n returns high is accepted normally.
REQ-024 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-025 Macro MULDIV_DIV_EN defined: DIVU and REMU SHALL behave as REQ-014 to REQ-019.
REQ-026 MULDIV_DIV_EN undefined: the divide datapath SHALL be omitted.
  - DIVU and REMU keep identical handshake and 33-cycle latency.
  - They return result=32'h0.
  - MUL and MULHU are unchanged.

Structure
REQ-027 A shared package muldiv_pkg SHALL hold:
  - op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU);
  - the FSM state encodings (S_IDLE, S_RUN, S_DONE);
  - the constant ITER_COUNT=32.
REQ-028 A sub-module muldiv_ctrl SHALL contain the FSM, the iteration counter and the busy/done generation; the shift-add/shift-subtract datapath stays in muldiv_unit.

Verification
REQ-029 MUL, a=7, b=6 -> result=42; done exactly 33 cycles after the start edge; busy high for 33 cycles.
REQ-030 a=b=32'hFFFFFFFF -> MUL result=32'h00000001; MULHU result=32'hFFFFFFFE.
REQ-031 a=100, b=7 -> DIVU result=14; REMU result=2. With MULDIV_DIV_EN undefined, both return 0 at the same latency.
REQ-032 Divide by zero, a=32'h00001234, b=0 -> DIVU result=32'hFFFFFFFF; REMU result=32'h00001234.
REQ-033 Handshake and reset checks:
  - MUL 3*5 started, then start with DIVU 9/3 at iteration 10 -> ignored; result=15.
  - Back-to-back start in the DONE cycle -> accepted; next done 33 cycles later.
REQ-034 rst_n=0 at iteration 10 of MUL 3*5 -> busy=0, done never pulses, result=0; a following MUL 4*4 yields 16.
